// File: rtl/mccoy_sequencer.sv
// Program buffer and run controller for the McCoy core: loads a 6-bit instruction stream,
// then runs the core from it. Optional watchdog enabled by defining MCCOY_SEQ_WDOG_EN.
module mccoy_sequencer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter logic [7:0]  MAX_CYCLES = 8'd255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_load,
    input  logic          start_run,
    input  logic          stop,
    input  logic          cmd_valid,
    input  logic [5:0]    cmd_data,
    output logic          cmd_ready,
    input  logic [7:0]    pc,
    output logic [5:0]    instr_out,
    output logic          core_reset,
    output logic [1:0]    state,
    output logic          halted,
    output logic          timeout,
    output logic [AW:0]   load_count,
    output logic [7:0]    run_cycles
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StHalt = 2'b11
    } state_e;

`ifdef MCCOY_SEQ_WDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d, count_inc;
    logic [7:0]    cycles_q, cycles_d;
    logic          timeout_q, timeout_d;
    logic          core_reset_q;
    logic          halted_q;
    logic          accept;
    logic          pc_in_range;
    logic          wdog_fire;
    logic [5:0]    mem [DEPTH];

    assign cmd_ready   = (state_q == StLoad) && (count_q < DepthW);
    assign accept      = cmd_ready && cmd_valid;
    assign count_inc   = count_q + (AW+1)'(accept);
    // Zero-extended compare so pc values beyond the buffer never alias into it.
    assign pc_in_range = ({1'b0, pc} < 9'(count_q));
    assign wdog_fire   = WdogEn && (state_q == StRun) && (cycles_q == MAX_CYCLES);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (start_load) begin
                    state_d = StLoad;
                    count_d = '0;
                end else if (start_run && (count_q != '0)) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                // A word accepted alongside start_run still counts toward the RUN check.
                count_d = count_inc;
                if (start_run) begin
                    state_d = (count_inc != '0) ? StRun : StIdle;
                end else if (stop) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (cycles_q != 8'hFF) begin
                    cycles_d = cycles_q + 8'd1;
                end
                if (!pc_in_range || stop || wdog_fire) begin
                    state_d = StHalt;
                end
                if (wdog_fire) begin
                    timeout_d = 1'b1;
                end
            end
            StHalt: begin
                if (start_load) begin
                    state_d = StLoad;
                    count_d = '0;
                end else if (start_run) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        if ((state_d == StRun) && (state_q != StRun)) begin
            cycles_d  = '0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            core_reset_q <= (state_d != StRun);
            halted_q     <= (state_d == StHalt);
        end
    end

    // Buffer is deliberately not reset; load_count alone defines the valid program.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem[count_q[AW-1:0]] <= cmd_data;
        end
    end

    assign instr_out  = ((state_q == StRun) && pc_in_range) ? mem[pc[AW-1:0]] : 6'b000000;
    assign core_reset = core_reset_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign load_count = count_q;
    assign run_cycles = cycles_q;

endmodule

// File: tb/tb_mccoy_sequencer.sv
// Directed self-checking bench for mccoy_sequencer; exercises the watchdog when
// MCCOY_SEQ_WDOG_EN is defined, otherwise counter saturation.
module tb_mccoy_sequencer;

`ifdef MCCOY_SEQ_WDOG_EN
    localparam logic [7:0] MaxCycles = 8'd10;
`else
    localparam logic [7:0] MaxCycles = 8'd255;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_load = 1'b0;
    logic       start_run = 1'b0;
    logic       stop = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [5:0] cmd_data = '0;
    logic       cmd_ready;
    logic [7:0] pc = '0;
    logic [5:0] instr_out;
    logic       core_reset;
    logic [1:0] state;
    logic       halted;
    logic       timeout;
    logic [4:0] load_count;
    logic [7:0] run_cycles;

    int errors = 0;
    int checks = 0;

    mccoy_sequencer #(
        .DEPTH      (16),
        .AW         (4),
        .MAX_CYCLES (MaxCycles)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_load (start_load),
        .start_run  (start_run),
        .stop       (stop),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .pc         (pc),
        .instr_out  (instr_out),
        .core_reset (core_reset),
        .state      (state),
        .halted     (halted),
        .timeout    (timeout),
        .load_count (load_count),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b want=00", state); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got=%b want=1", core_reset); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
        checks++; if (load_count !== 5'd0) begin errors++; $display("FAIL reset_load_count got=%0d want=0", load_count); end
        checks++; if (instr_out !== 6'h00) begin errors++; $display("FAIL reset_instr got=%h want=00", instr_out); end
        checks++; if (halted !== 1'b0 || timeout !== 1'b0 || run_cycles !== 8'd0) begin
            errors++; $display("FAIL reset_misc got halted=%b timeout=%b cycles=%0d want 0/0/0", halted, timeout, run_cycles);
        end
        reset = 1'b1;
    endtask

    task automatic test_load();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL load_state got=%b want=01", state); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b want=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_data = 6'h05; tick();
        cmd_data = 6'h2A; tick();
        cmd_valid = 1'b0; tick();
        cmd_valid = 1'b1; cmd_data = 6'h11; tick();
        cmd_valid = 1'b0;
        checks++; if (load_count !== 5'd3) begin errors++; $display("FAIL load_count got=%0d want=3", load_count); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL load_core_reset got=%b want=1", core_reset); end
    endtask

    task automatic test_run();
        logic [5:0] exp [4];
        exp[0] = 6'h05; exp[1] = 6'h2A; exp[2] = 6'h11; exp[3] = 6'h00;
        pc = 8'd0;
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
        checks++; if (state !== 2'b10 || core_reset !== 1'b0) begin
            errors++; $display("FAIL run_entry got state=%b core_reset=%b want 10/0", state, core_reset);
        end
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            #1;
            checks++; if (instr_out !== exp[i]) begin errors++; $display("FAIL run_instr pc=%0d got=%h want=%h", i, instr_out, exp[i]); end
            checks++; if (state !== 2'b10) begin errors++; $display("FAIL run_still pc=%0d got=%b want=10", i, state); end
            tick();
        end
        checks++; if (state !== 2'b11 || halted !== 1'b1 || core_reset !== 1'b1) begin
            errors++; $display("FAIL run_halt got state=%b halted=%b core_reset=%b want 11/1/1", state, halted, core_reset);
        end
        checks++; if (instr_out !== 6'h00 || run_cycles !== 8'd4) begin
            errors++; $display("FAIL run_halt_out got instr=%h cycles=%0d want 00/4", instr_out, run_cycles);
        end
    endtask

    task automatic test_stop();
        pc = 8'd0;
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
        checks++; if (state !== 2'b10 || run_cycles !== 8'd0) begin
            errors++; $display("FAIL stop_rerun got state=%b cycles=%0d want 10/0", state, run_cycles);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (state !== 2'b11 || timeout !== 1'b0 || run_cycles !== 8'd1) begin
            errors++; $display("FAIL stop_halt got state=%b timeout=%b cycles=%0d want 11/0/1", state, timeout, run_cycles);
        end
    endtask

    task automatic test_priority();
        reset = 1'b0; tick(); reset = 1'b1;
        start_run = 1'b1; tick(); start_run = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL prio_empty_run got=%b want=00", state); end
        start_load = 1'b1; start_run = 1'b1; tick(); start_load = 1'b0; start_run = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL prio_load_wins got=%b want=01", state); end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL prio_load_stop got=%b want=00", state); end
        start_load = 1'b1; tick(); start_load = 1'b0;
        start_run = 1'b1; tick(); start_run = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL prio_load_empty_run got=%b want=00", state); end
        // Word accepted in the same cycle as start_run
        start_load = 1'b1; tick(); start_load = 1'b0;
        pc = 8'd0; cmd_valid = 1'b1; cmd_data = 6'h3F; start_run = 1'b1;
        tick();
        cmd_valid = 1'b0; start_run = 1'b0;
        checks++; if (state !== 2'b10 || load_count !== 5'd1 || instr_out !== 6'h3F) begin
            errors++; $display("FAIL prio_same_cycle got state=%b count=%0d instr=%h want 10/1/3f", state, load_count, instr_out);
        end
        pc = 8'd1;
        #1;
        checks++; if (instr_out !== 6'h00) begin errors++; $display("FAIL prio_oob_instr got=%h want=00", instr_out); end
        tick();
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL prio_oob_halt got=%b want=11", state); end
    endtask

    task automatic test_full();
        start_load = 1'b1; tick(); start_load = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cmd_valid = 1'b1;
            cmd_data = 6'(i * 3 + 1);
            tick();
            if (i == 15) begin
                checks++; if (load_count !== 5'd16 || cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL full_after16 got count=%0d ready=%b want 16/0", load_count, cmd_ready);
                end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (load_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d want=16", load_count); end
        pc = 8'd0;
        start_run = 1'b1; tick(); start_run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc = 8'(i);
            #1;
            checks++; if (instr_out !== 6'(i * 3 + 1)) begin
                errors++; $display("FAIL full_word pc=%0d got=%h want=%h", i, instr_out, 6'(i * 3 + 1));
            end
            tick();
        end
        pc = 8'd16;
        #1;
        checks++; if (instr_out !== 6'h00) begin errors++; $display("FAIL full_oob got=%h want=00", instr_out); end
        tick();
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL full_halt got=%b want=11", state); end
    endtask

    task automatic test_watchdog();
        pc = 8'd0;
        start_run = 1'b1; tick(); start_run = 1'b0;
`ifdef MCCOY_SEQ_WDOG_EN
        repeat (10) tick();
        checks++; if (state !== 2'b10 || run_cycles !== 8'd10) begin
            errors++; $display("FAIL wdog_pre got state=%b cycles=%0d want 10/10", state, run_cycles);
        end
        tick();
        checks++; if (state !== 2'b11 || timeout !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL wdog_fire got state=%b timeout=%b halted=%b want 11/1/1", state, timeout, halted);
        end
`else
        repeat (300) tick();
        checks++; if (state !== 2'b10 || run_cycles !== 8'd255) begin
            errors++; $display("FAIL sat_run got state=%b cycles=%0d want 10/255", state, run_cycles);
        end
        checks++; if (timeout !== 1'b0 || core_reset !== 1'b0) begin
            errors++; $display("FAIL sat_flags got timeout=%b core_reset=%b want 0/0", timeout, core_reset);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (state !== 2'b11 || run_cycles !== 8'd255) begin
            errors++; $display("FAIL sat_stop got state=%b cycles=%0d want 11/255", state, run_cycles);
        end
`endif
    endtask

    task automatic test_mid_reset();
        pc = 8'd0;
        start_run = 1'b1; tick(); start_run = 1'b0;
        checks++; if (timeout !== 1'b0 || state !== 2'b10) begin
            errors++; $display("FAIL midrst_entry got timeout=%b state=%b want 0/10", timeout, state);
        end
        repeat (5) tick();
        checks++; if (run_cycles !== 8'd5) begin errors++; $display("FAIL midrst_cycles got=%0d want=5", run_cycles); end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (state !== 2'b00 || core_reset !== 1'b1) begin
            errors++; $display("FAIL midrst_state got state=%b core_reset=%b want 00/1", state, core_reset);
        end
        checks++; if (load_count !== 5'd0 || run_cycles !== 8'd0) begin
            errors++; $display("FAIL midrst_counts got count=%0d cycles=%0d want 0/0", load_count, run_cycles);
        end
        start_run = 1'b1; tick(); start_run = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL midrst_discard got=%b want=00", state); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_stop();
        test_priority();
        test_full();
        test_watchdog();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
